// File: rtl/bti_pkg.sv
// -----------------------------------------------------------------------------
// bti_pkg -- shared BTI bus definitions.
//
// Holds the command encoding, the transaction-id width and the packed request
// and response packets. It also holds the depth of the TCM response buffer.
// Every BTI agent and slave imports these types and does not redeclare them.
// -----------------------------------------------------------------------------
package bti_pkg;

  // Transaction id width; responses echo the id of their request.
  localparam int unsigned BTI_TID_W = 4;

  // Entries in the TCM response FIFO.
  localparam int unsigned BTI_RSP_FIFO_DEPTH = 2;

  typedef logic [BTI_TID_W-1:0] bti_tid_t;

  typedef enum logic [0:0] {
    BTI_CMD_READ  = 1'b0,
    BTI_CMD_WRITE = 1'b1
  } bti_cmd_e;

  // Request packet: byte address, write data and per-byte write strobe.
  typedef struct packed {
    bti_tid_t    tid;
    bti_cmd_e    cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strobe;
  } bti_req_pkt_t;

  // Response packet: ok=0 flags an access that hit no memory.
  typedef struct packed {
    bti_tid_t    tid;
    logic [31:0] data;
    logic        ok;
  } bti_rsp_pkt_t;

endpackage

// File: rtl/bti_if.sv
// -----------------------------------------------------------------------------
// BTI request and response channels.
//
// Both channels use a valid/ready handshake. A transfer happens in a cycle
// where vld && rdy. The master drives vld and pkt. The slave drives rdy.
//   bti_req_if_t : vld, rdy, pkt (bti_req_pkt_t)
//   bti_rsp_if_t : vld, rdy, pkt (bti_rsp_pkt_t)
// -----------------------------------------------------------------------------
interface bti_req_if_t;
  import bti_pkg::*;

  logic         vld;
  logic         rdy;
  bti_req_pkt_t pkt;

  modport mst (output vld, output pkt, input  rdy);
  modport slv (input  vld, input  pkt, output rdy);
endinterface

interface bti_rsp_if_t;
  import bti_pkg::*;

  logic         vld;
  logic         rdy;
  bti_rsp_pkt_t pkt;

  modport mst (output vld, output pkt, input  rdy);
  modport slv (input  vld, input  pkt, output rdy);
endinterface

// File: rtl/bti_rsp_fifo.sv
// -----------------------------------------------------------------------------
// bti_rsp_fifo -- small synchronous FIFO of BTI response packets.
//
// Ports:
//   clk, rst_n : clock and synchronous active-low reset.
//                Reset clears the count and the pointers only.
//   push       : write push_pkt this cycle.
//                A push while full is accepted only if pop is also high.
//   push_pkt   : packet to enqueue.
//   pop        : remove the head entry. It is ignored when the FIFO is empty.
//   head       : oldest entry. It is valid while not_empty is high.
//   not_empty  : the FIFO holds at least one entry.
//   cnt        : number of entries held, 0..DEPTH.
//
// DEPTH must be a power of two so that the pointers wrap on overflow.
// A push and a pop in the same cycle leave cnt unchanged, even when the
// FIFO is full. The slot being freed takes the new tail.
// -----------------------------------------------------------------------------
module bti_rsp_fifo
  import bti_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  bti_rsp_pkt_t  push_pkt,
  input  logic          pop,
  output bti_rsp_pkt_t  head,
  output logic          not_empty,
  output logic [CW-1:0] cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  bti_rsp_pkt_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign not_empty = (cnt != '0);
  assign do_pop    = pop && not_empty;
  // When full, space opens only if the head leaves in the same cycle.
  assign do_push   = push && ((cnt < CW'(DEPTH)) || do_pop);

  // NOTE: state registers use non-blocking (<=) so every flop samples
  // pre-edge values no matter how the always blocks are ordered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: payload storage is deliberately left out of reset. The pointers and
  // the count decide which entries are live, so a reset only needs to clear
  // them. Leaving the storage alone lets it map onto plain, reset-less flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_pkt;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bti_tcm.sv
// -----------------------------------------------------------------------------
// bti_tcm -- BTI slave in front of a single-port 32-bit SRAM (tightly coupled
// memory).
//
// Ports:
//   clk, rst_n   : clock and synchronous active-low reset.
//   bti_req_slv  : request channel (tid, cmd, byte addr, data, strobe).
//   bti_rsp_mst  : response channel (tid, data, ok).
//   sram_cs      : SRAM access enable. It is high only in the cycle a request
//                  is accepted, and only when the address falls inside the
//                  memory window.
//   sram_we      : write enable. It is meaningful only with sram_cs.
//   sram_addr    : word index, (addr - BASE) >> 2.
//   sram_wdata   : write data.
//   sram_wstrb   : byte write mask.
//   sram_rdata   : read data. It arrives the cycle after the read access.
//
// Pipeline:
//   The SRAM is accessed in the accept cycle T. Stage S1 holds the request
//   metadata in cycle T+1, while the SRAM returns the read data. At the end
//   of T+1 the response enters the FIFO, and the FIFO head shows it at T+2.
//   req.rdy is withheld when S1 plus the FIFO would exceed the FIFO depth,
//   unless a response leaves in that same cycle. This way the FIFO never
//   overflows.
//   An address outside [BASE, BASE+4*DEPTH) gets ok=0 and data=0, and it
//   never reaches the SRAM.
// -----------------------------------------------------------------------------
module bti_tcm
  import bti_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bti_req_if_t.slv                 bti_req_slv,
  bti_rsp_if_t.mst                 bti_rsp_mst,
  output logic                     sram_cs,
  output logic                     sram_we,
  output logic [$clog2(DEPTH)-1:0] sram_addr,
  output logic [31:0]              sram_wdata,
  output logic [3:0]               sram_wstrb,
  input  logic [31:0]              sram_rdata
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(BTI_RSP_FIFO_DEPTH + 1);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  // ---------------------------------------------------------------------------
  // Accept and address decode
  // ---------------------------------------------------------------------------
  logic        accept;
  logic        in_range;
  logic [32:0] offset;
  logic        rsp_pop;

  // 33-bit subtraction: bit 32 goes high when addr < BASE, and the upper
  // compare needs no BASE+SPAN term, which could overflow 32 bits.
  assign offset   = {1'b0, bti_req_slv.pkt.addr} - {1'b0, BASE};
  assign in_range = !offset[32] && (offset < SPAN);
  assign accept   = bti_req_slv.vld && bti_req_slv.rdy;

  assign sram_cs    = accept && in_range;
  assign sram_we    = sram_cs && (bti_req_slv.pkt.cmd == BTI_CMD_WRITE);
  assign sram_addr  = offset[AW+1:2];
  assign sram_wdata = bti_req_slv.pkt.data;
  assign sram_wstrb = bti_req_slv.pkt.strobe;

  // ---------------------------------------------------------------------------
  // Stage S1: metadata of the request whose SRAM access is in flight
  // ---------------------------------------------------------------------------
  logic     s1_vld;
  bti_tid_t s1_tid;
  logic     s1_is_read;
  logic     s1_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) s1_vld <= 1'b0;
    else        s1_vld <= accept;
  end

  // The payload is qualified by s1_vld, so it reloads only on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_tid     <= bti_req_slv.pkt.tid;
      s1_is_read <= (bti_req_slv.pkt.cmd == BTI_CMD_READ);
      s1_ok      <= in_range;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  bti_rsp_pkt_t  push_pkt;
  bti_rsp_pkt_t  fifo_head;
  logic          fifo_not_empty;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   occupancy;

  // sram_rdata is valid exactly during S1, so it is captured as S1 drains.
  assign push_pkt.tid  = s1_tid;
  assign push_pkt.ok   = s1_ok;
  assign push_pkt.data = (s1_is_read && s1_ok) ? sram_rdata : 32'h0;

  bti_rsp_fifo #(
    .DEPTH (BTI_RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s1_vld),
    .push_pkt  (push_pkt),
    .pop       (rsp_pop),
    .head      (fifo_head),
    .not_empty (fifo_not_empty),
    .cnt       (fifo_cnt)
  );

  // ---------------------------------------------------------------------------
  // Channel handshakes
  // ---------------------------------------------------------------------------
  // rst_n gates both valid and ready, so nothing is offered or taken during
  // reset, even though the FIFO state clears only at the reset edge.
  assign bti_rsp_mst.vld = rst_n && fifo_not_empty;
  assign bti_rsp_mst.pkt = fifo_head;
  assign rsp_pop         = bti_rsp_mst.vld && bti_rsp_mst.rdy;

  // Responses already owed (FIFO entries plus S1) must leave room for one
  // more request. A pop in the same cycle frees a slot. That creates a
  // combinational rsp.rdy -> req.rdy path, which is what sustains one
  // request per cycle under a full pipeline.
  assign occupancy       = {1'b0, fifo_cnt} + (CW+1)'(s1_vld);
  assign bti_req_slv.rdy = rst_n &&
                           ((occupancy < (CW+1)'(BTI_RSP_FIFO_DEPTH)) || rsp_pop);

endmodule

// File: doc/bti_tcm.md
BTI_TCM -- requirements
Module: bti_tcm

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, meaning number of 32-bit words in the attached SRAM (power of 2).
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, meaning byte address of word 0.
REQ-003 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port bti_req_slv  bti_req_if_t.slv  -  request channel: vld/rdy, pkt.tid/cmd/addr/data/strobe.
REQ-006 SHALL have port bti_rsp_mst  bti_rsp_if_t.mst  -  response channel: vld/rdy, pkt.tid/data/ok.
REQ-007 SHALL have port sram_cs  output  1  SRAM access enable.
REQ-008 SHALL have port sram_we  output  1  SRAM write enable, valid only with sram_cs.
REQ-009 SHALL have port sram_addr  output  $clog2(DEPTH)  SRAM word index.
REQ-010 SHALL have port sram_wdata  output  32  SRAM write data.
REQ-011 SHALL have port sram_wstrb  output  4  SRAM byte write mask.
REQ-012 SHALL have port sram_rdata  input  32  SRAM read data, valid the cycle after a read access.

Function
REQ-013 SHALL accept a request when bti_req_slv.vld && bti_req_slv.rdy, called "accept" below.
REQ-014 SHALL assert sram_cs combinationally in the accept cycle only if the address is in range, i.e. BASE <= addr < BASE+4*DEPTH.
REQ-015 SHALL drive sram_addr = (addr-BASE)>>2, ignoring addr[1:0].
REQ-016 SHALL drive sram_we = (cmd==BTI_CMD_WRITE), with sram_wdata/sram_wstrb taken from pkt.data/pkt.strobe.
REQ-017 SHALL hold one stage register S1 (vld, tid, is_read, ok) loaded on accept; S1 captures sram_rdata for reads at the end of the S1 cycle.
REQ-018 SHALL push S1 into a 2-entry response FIFO every cycle S1.vld=1; the FIFO head drives bti_rsp_mst.
REQ-019 SHALL make the response for a request accepted in cycle T visible on bti_rsp_mst.vld in cycle T+2 when the FIFO is empty.
REQ-020 SHALL set response data = sram_rdata for in-range reads and 0 for writes and out-of-range accesses.
REQ-021 SHALL set ok = 1 for in-range accesses and ok = 0 for out-of-range accesses; an out-of-range access SHALL NOT touch the SRAM.
REQ-022 SHALL echo the request tid in the response.
REQ-023 SHALL return responses strictly in acceptance order.
REQ-024 SHALL drive bti_req_slv.rdy = (fifo_cnt + S1.vld < 2) || (bti_rsp_mst.vld && bti_rsp_mst.rdy), so the FIFO never overflows; this combinational rsp.rdy->req.rdy path is permitted.
REQ-025 SHALL sustain one request per cycle while bti_rsp_mst.rdy is held high.
REQ-026 SHALL keep bti_rsp_mst.pkt stable while vld=1 && rdy=0.
REQ-027 SHALL allow push and pop of the FIFO in the same cycle, including when it is full; fifo_cnt is then unchanged.
REQ-028 SHALL keep fifo pointers 1 bit wide, wrapping naturally modulo 2.

Reset
REQ-029 SHALL clear S1.vld, fifo_cnt and the FIFO pointers in any cycle where rst_n=0.
REQ-030 SHALL hold bti_rsp_mst.vld=0, bti_req_slv.rdy=0 and sram_cs=0 while rst_n=0.
REQ-031 SHALL discard any in-flight or buffered responses on a mid-operation reset, with no SRAM write issued during reset.
REQ-032 SHALL leave FIFO payload storage unreset.

Structure
REQ-033 SHALL use the BTI_CMD_* enum, the BTI tid width and the packet typedefs from the shared bti package/header; no local redefinition.
REQ-034 SHALL implement the response FIFO as sub-module bti_rsp_fifo (parameterised on depth, default 2; payload = bti response packet).

Verification
REQ-035 SHALL cover: read addr 0x10 with SRAM word 4 = 0xDEADBEEF, rsp.rdy=1 -> rsp vld at T+2, data 0xDEADBEEF, ok=1, matching tid.
REQ-036 SHALL cover: write addr 0x8, data 0x11223344, strobe 4'b0011, then read 0x8 with prior content 0xAABBCCDD -> read returns 0xAABB3344, write rsp data 0, ok=1.
REQ-037 SHALL cover: read addr BASE+4*DEPTH -> sram_cs never asserts, rsp ok=0, data 0.
REQ-038 SHALL cover: 8 back-to-back reads, tid 0..7, rsp.rdy=1 -> req.rdy stays 1, 8 responses in consecutive cycles in tid order.
REQ-039 SHALL cover: rsp.rdy=0 for 5 cycles under continuous requests -> exactly 2 accepted before req.rdy=0, the FIFO head is stable, and no response is lost after rsp.rdy=1.
REQ-040 SHALL cover: rst_n low for 1 cycle with 2 responses buffered -> rsp.vld=0 next cycle and no stale response thereafter.
